// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RD_WAIT
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: on contention the port not
// granted last time wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter between an instruction fetch
// port and a load/store port, with fixed-latency reads.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t     state;
  logic       cur;
  logic       last_grant;
  logic       lat_we;
  logic [1:0] cnt;
  logic [1:0] elig;
  logic [1:0] gnt;
  logic       gnt_valid;
  logic       sel;

  // A port whose ack is showing this cycle sits out one round.
  assign elig = {d_req & ~d_ack, f_req & ~f_ack};

  rr_arbiter2 u_rr (
    .req   (elig),
    .last  (last_grant),
    .gnt   (gnt),
    .valid (gnt_valid)
  );

  assign sel  = gnt[PORT_D] & ~gnt[PORT_F];
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cur        <= PORT_F;
      last_grant <= PORT_D;
      lat_we     <= 1'b0;
      cnt        <= '0;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      f_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      f_ack  <= 1'b0;
      d_ack  <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            cur        <= sel;
            last_grant <= sel;
            lat_we     <= sel & d_we;
            mem_addr   <= sel ? d_addr : f_addr;
            mem_wdata  <= sel ? d_wdata : '0;
            mem_en     <= 1'b1;
            mem_we     <= sel & d_we;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_we) begin
            d_ack <= cur;
            f_ack <= ~cur;
            state <= IDLE;
          end else begin
            cnt   <= 2'(RD_LATENCY - 1);
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt == 2'd0) begin
            if (cur) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              f_rdata <= mem_rdata;
              f_ack   <= 1'b1;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: four instances, RD_LATENCY 1..4.
module tb_mem_arbiter;

  localparam int N = 4;

  typedef struct {
    logic        port;
    logic [31:0] fr;
    logic [31:0] dr;
    int          cyc;
  } ack_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    int          cyc;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst       [N];
  logic        f_req     [N];
  logic [31:0] f_addr    [N];
  logic        f_ack     [N];
  logic [31:0] f_rdata   [N];
  logic        d_req     [N];
  logic        d_we      [N];
  logic [31:0] d_addr    [N];
  logic [31:0] d_wdata   [N];
  logic        d_ack     [N];
  logic [31:0] d_rdata   [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];
  logic        busy      [N];

  ack_t        ackq [N][$];
  acc_t        accq [N][$];
  logic [31:0] mf [N];
  logic [31:0] md [N];

  int cyc  = 0;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_fn(logic [31:0] a);
    case (a)
      32'h40:  return 32'hDEADBEEF;
      32'h80:  return 32'hCAFEF00D;
      32'h200: return 32'h0BADC0DE;
      32'h300: return 32'h13572468;
      default: return ~a;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    int          mcnt = 0;
    logic [31:0] maddr = '0;

    mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .RD_LATENCY(g + 1)
    ) dut (
      .clk(clk), .reset(rst[g]),
      .f_req(f_req[g]), .f_addr(f_addr[g]),
      .f_ack(f_ack[g]), .f_rdata(f_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]),
      .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    // read data is only valid exactly RD_LATENCY edges after mem_en
    always @(posedge clk) begin
      if (mem_en[g] && !mem_we[g]) begin
        mcnt  <= g + 1;
        maddr <= mem_addr[g];
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
      end
    end
    assign mem_rdata[g] = (mcnt == 1) ? mem_fn(maddr) : 32'hBAD0BAD0;
  end

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: pop and compare whenever a DUT presents mem_en or an ack
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mem_en[i] === 1'b1) begin
        vecs++;
        if (accq[i].size() == 0) begin
          errs++;
          $display("FAIL acc%0d: unexpected mem_en addr=%h cyc=%0d",
                   i, mem_addr[i], cyc);
        end else begin
          acc_t e;
          e = accq[i].pop_front();
          if (mem_addr[i] !== e.addr || mem_we[i] !== e.we ||
              (e.we && mem_wdata[i] !== e.wd) || cyc != e.cyc) begin
            errs++;
            $display("FAIL acc%0d: got a=%h we=%b wd=%h c=%0d want a=%h we=%b wd=%h c=%0d",
                     i, mem_addr[i], mem_we[i], mem_wdata[i], cyc,
                     e.addr, e.we, e.wd, e.cyc);
          end
        end
      end
      if (mem_we[i] === 1'b1 && mem_en[i] !== 1'b1) begin
        vecs++;
        errs++;
        $display("FAIL we%0d: mem_we=1 with mem_en=%b cyc=%0d", i, mem_en[i], cyc);
      end
      if (f_ack[i] === 1'b1 || d_ack[i] === 1'b1) begin
        vecs++;
        if (f_ack[i] === 1'b1 && d_ack[i] === 1'b1) begin
          errs++;
          $display("FAIL ack%0d: f_ack and d_ack both high cyc=%0d", i, cyc);
        end else if (ackq[i].size() == 0) begin
          errs++;
          $display("FAIL ack%0d: unexpected ack f=%b d=%b cyc=%0d",
                   i, f_ack[i], d_ack[i], cyc);
        end else begin
          ack_t e;
          e = ackq[i].pop_front();
          if (d_ack[i] !== e.port || f_rdata[i] !== e.fr ||
              d_rdata[i] !== e.dr || cyc != e.cyc) begin
            errs++;
            $display("FAIL ack%0d: got port=%b fr=%h dr=%h c=%0d want port=%b fr=%h dr=%h c=%0d",
                     i, d_ack[i], f_rdata[i], d_rdata[i], cyc,
                     e.port, e.fr, e.dr, e.cyc);
          end
        end
      end
    end
  end

  task automatic push_acc(int i, logic [31:0] a, logic we, logic [31:0] wd, int c);
    acc_t e;
    e.addr = a; e.we = we; e.wd = wd; e.cyc = c;
    accq[i].push_back(e);
  endtask

  task automatic push_ack(int i, logic p, int c);
    ack_t e;
    e.port = p; e.fr = mf[i]; e.dr = md[i]; e.cyc = c;
    ackq[i].push_back(e);
  endtask

  // one-cycle request pulse, then scrambled inputs while in flight
  task automatic read_op(int i, logic p, logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    if (p) begin
      d_req[i] = 1'b1; d_we[i] = 1'b0; d_addr[i] = a; md[i] = d;
    end else begin
      f_req[i] = 1'b1; f_addr[i] = a; mf[i] = d;
    end
    push_acc(i, a, 1'b0, 32'h0, cyc + 1);
    push_ack(i, p, cyc + 3 + i);
    @(negedge clk);
    f_req[i] = 1'b0; d_req[i] = 1'b0;
    f_addr[i] = 32'hFFFF_FFF0; d_addr[i] = 32'hFFFF_FFF4; d_we[i] = 1'b1;
    repeat (i + 3) @(negedge clk);
    d_we[i] = 1'b0;
  endtask

  task automatic write_op(int i, logic [31:0] a, logic [31:0] wd);
    @(negedge clk);
    d_req[i] = 1'b1; d_we[i] = 1'b1; d_addr[i] = a; d_wdata[i] = wd;
    push_acc(i, a, 1'b1, wd, cyc + 1);
    push_ack(i, 1'b1, cyc + 2);
    @(negedge clk);
    d_req[i] = 1'b0; d_we[i] = 1'b0; d_wdata[i] = 32'h0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n0;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b0; f_req[i] = 1'b0; f_addr[i] = '0;
      d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
      mf[i] = '0; md[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_ctl%0d", i),
            {59'd0, busy[i], f_ack[i], d_ack[i], mem_en[i], mem_we[i]}, 64'd0);
      check($sformatf("rst_dat%0d", i),
            {32'd0, mem_addr[i] | mem_wdata[i] | f_rdata[i] | d_rdata[i]}, 64'd0);
      rst[i] = 1'b1;
    end
    @(negedge clk);

    read_op(0, 1'b0, 32'h40, 32'hDEADBEEF);
    write_op(0, 32'h100, 32'h12345678);

    // both ports held: F, D, F, D
    @(negedge clk);
    n0 = cyc;
    f_req[0] = 1'b1; f_addr[0] = 32'h40;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h300; d_wdata[0] = 32'hA5A50001;
    mf[0] = 32'hDEADBEEF;
    push_acc(0, 32'h40, 1'b0, 32'h0, n0 + 1);
    push_acc(0, 32'h300, 1'b1, 32'hA5A50001, n0 + 4);
    push_acc(0, 32'h40, 1'b0, 32'h0, n0 + 6);
    push_acc(0, 32'h300, 1'b1, 32'hA5A50001, n0 + 9);
    push_ack(0, 1'b0, n0 + 3);
    push_ack(0, 1'b1, n0 + 5);
    push_ack(0, 1'b0, n0 + 8);
    push_ack(0, 1'b1, n0 + 10);
    repeat (9) @(negedge clk);
    f_req[0] = 1'b0; d_req[0] = 1'b0; d_we[0] = 1'b0;
    repeat (3) @(negedge clk);

    read_op(0, 1'b1, 32'h80, 32'hCAFEF00D);

    // load request held through its own ack cycle
    @(negedge clk);
    n0 = cyc;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h200; md[0] = 32'h0BADC0DE;
    push_acc(0, 32'h200, 1'b0, 32'h0, n0 + 1);
    push_ack(0, 1'b1, n0 + 3);
    repeat (4) @(negedge clk);
    d_req[0] = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < N; i++) begin
      read_op(i, 1'b0, 32'h200, 32'h0BADC0DE);
      read_op(i, 1'b1, 32'h80, 32'hCAFEF00D);
    end

    // reset during RD_WAIT on the latency-3 instance
    @(negedge clk);
    n0 = cyc;
    f_req[2] = 1'b1; f_addr[2] = 32'h40;
    push_acc(2, 32'h40, 1'b0, 32'h0, n0 + 1);
    @(negedge clk);
    f_req[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst[2] = 1'b0;
    @(negedge clk);
    check("midrst_ctl",
          {59'd0, busy[2], f_ack[2], d_ack[2], mem_en[2], mem_we[2]}, 64'd0);
    check("midrst_dat",
          {32'd0, mem_addr[2] | mem_wdata[2] | f_rdata[2] | d_rdata[2]}, 64'd0);
    rst[2] = 1'b1;
    mf[2] = '0; md[2] = '0;
    repeat (6) @(negedge clk);
    read_op(2, 1'b1, 32'h300, 32'h13572468);

    write_op(3, 32'h500, 32'h55AA55AA);
    read_op(3, 1'b1, 32'h300, 32'h13572468);

    repeat (6) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("drain_ack%0d", i), 64'(ackq[i].size()), 64'd0);
      check($sformatf("drain_acc%0d", i), 64'(accq[i].size()), 64'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
